// File: rtl/iir_cascade_scheduler.sv
// iir_cascade_scheduler: time-shares one MAC across cascaded stereo biquads fed from I2S samples
module iir_cascade_scheduler #(
  parameter int N_STAGES = 3,
  parameter int FRAC = 14,
  localparam int AW = $clog2(5*N_STAGES),
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l_r_clk,
  input  logic signed [15:0]  sample_in,
  output logic [AW-1:0]       coef_addr,
  input  logic signed [15:0]  coef_data,
  output logic signed [15:0]  mac_a,
  output logic signed [15:0]  mac_b,
  output logic                mac_rst,
  output logic                mac_ce,
  input  logic signed [31:0]  mac_result,
  output logic signed [15:0]  out_left,
  output logic signed [15:0]  out_right,
  output logic                out_valid,
  output logic                out_chan,
  output logic                busy,
  output logic                overrun
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_WB, S_DONE} state_t;
  localparam logic signed [32:0] RND = 33'sd1 <<< (FRAC-1);
  state_t state_q;
  logic [2:0] tap_q;
  logic [SW-1:0] stage_q;
  logic d1_q, d2_q, pend_v_q, pend_c_q, cur_c_q, out_valid_q, out_chan_q, overrun_q;
  logic signed [15:0] pend_x_q, cur_x_q, out_left_q, out_right_q;
  logic signed [15:0] x1_q [2][N_STAGES];
  logic signed [15:0] x2_q [2][N_STAGES];
  logic signed [15:0] y1_q [2][N_STAGES];
  logic signed [15:0] y2_q [2][N_STAGES];
  logic lr_edge, pop, in_mac;
  logic signed [15:0] coef_neg, hist, y_d;
  logic signed [32:0] rnd, shr;
  assign lr_edge = d1_q ^ d2_q;
  assign pop = (state_q == S_IDLE) && pend_v_q;
  assign in_mac = state_q == S_MAC;
  // Operand routing for the current tap; feedback coefficients are negated with saturation
  always_comb begin
    coef_neg = (coef_data == 16'sh8000) ? 16'sh7fff : -coef_data;
    hist = (tap_q == 3'd0) ? cur_x_q :
           (tap_q == 3'd1) ? x1_q[cur_c_q][stage_q] :
           (tap_q == 3'd2) ? x2_q[cur_c_q][stage_q] :
           (tap_q == 3'd3) ? y1_q[cur_c_q][stage_q] : y2_q[cur_c_q][stage_q];
    mac_a = in_mac ? ((tap_q >= 3'd3) ? coef_neg : coef_data) : 16'sd0;
    mac_b = in_mac ? hist : 16'sd0;
    coef_addr = in_mac ? AW'(5*int'(stage_q) + int'(tap_q)) : '0;
    mac_rst = !in_mac;
    mac_ce = in_mac;
    rnd = $signed({mac_result[31], mac_result}) + RND;
    shr = rnd >>> FRAC;
    y_d = (shr > 33'sd32767) ? 16'sh7fff : (shr < -33'sd32768) ? 16'sh8000 : shr[15:0];
  end
  // Sample capture, pending slot and the stage/tap sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tap_q <= '0;
      stage_q <= '0;
      d1_q <= 1'b0;
      d2_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_c_q <= 1'b0;
      pend_x_q <= '0;
      cur_x_q <= '0;
      cur_c_q <= 1'b0;
      out_left_q <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      out_chan_q <= 1'b0;
      overrun_q <= 1'b0;
      x1_q <= '{default: '{default: '0}};
      x2_q <= '{default: '{default: '0}};
      y1_q <= '{default: '{default: '0}};
      y2_q <= '{default: '{default: '0}};
    end else begin
      d1_q <= l_r_clk;
      d2_q <= d1_q;
      out_valid_q <= 1'b0;
      if (lr_edge) begin
        pend_v_q <= 1'b1;
        pend_x_q <= sample_in;
        pend_c_q <= d1_q;
        if (pend_v_q && !pop) overrun_q <= 1'b1;
      end else if (pop) begin
        pend_v_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: if (pend_v_q) begin
          cur_x_q <= pend_x_q;
          cur_c_q <= pend_c_q;
          stage_q <= '0;
          state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          tap_q <= '0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          tap_q <= tap_q + 3'd1;
          if (tap_q == 3'd4) state_q <= S_WB;
        end
        S_WB: begin
          x2_q[cur_c_q][stage_q] <= x1_q[cur_c_q][stage_q];
          x1_q[cur_c_q][stage_q] <= cur_x_q;
          y2_q[cur_c_q][stage_q] <= y1_q[cur_c_q][stage_q];
          y1_q[cur_c_q][stage_q] <= y_d;
          cur_x_q <= y_d;
          if (stage_q == SW'(N_STAGES-1)) begin
            state_q <= S_DONE;
            out_valid_q <= 1'b1;
            out_chan_q <= cur_c_q;
            if (cur_c_q) out_right_q <= y_d;
            else out_left_q <= y_d;
          end else begin
            stage_q <= stage_q + 1'b1;
            state_q <= S_CLEAR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign out_left = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign out_chan = out_chan_q;
  assign busy = state_q != S_IDLE;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_iir_cascade_scheduler.sv
// tb_iir_cascade_scheduler: randomized stereo biquad-cascade bench against a per-channel arithmetic model
module tb_iir_cascade_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic l_r_clk = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic [3:0] coef_addr;
  logic signed [15:0] coef_data, mac_a, mac_b, out_left, out_right;
  logic mac_rst, mac_ce, out_valid, out_chan, busy, overrun;
  logic signed [31:0] mac_result;
  logic signed [31:0] acc = '0;
  logic signed [15:0] bank [16];
  int rx1 [2][3];
  int rx2 [2][3];
  int ry1 [2][3];
  int ry2 [2][3];
  int exp_v [$];
  int exp_c [$];
  int n_chk = 0;
  int n_pass = 0;
  int mon_v, mon_c, k;

  iir_cascade_scheduler #(.N_STAGES(3), .FRAC(14)) dut (
    .clk(clk), .reset(reset), .l_r_clk(l_r_clk), .sample_in(sample_in),
    .coef_addr(coef_addr), .coef_data(coef_data), .mac_a(mac_a), .mac_b(mac_b),
    .mac_rst(mac_rst), .mac_ce(mac_ce), .mac_result(mac_result),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_chan(out_chan), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  assign coef_data = bank[coef_addr];
  assign mac_result = acc;

  always @(posedge clk)
    if (mac_rst) acc <= '0;
    else if (mac_ce) acc <= acc + 32'(mac_a * mac_b);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int neg(input int a);
    return (a == -32768) ? 32767 : -a;
  endfunction

  function automatic int ref_run(input int c, input int x);
    int v, acc_m, y;
    longint r;
    v = x;
    for (int s = 0; s < 3; s++) begin
      acc_m = bank[s*5] * v + bank[s*5+1] * rx1[c][s] + bank[s*5+2] * rx2[c][s]
            + neg(bank[s*5+3]) * ry1[c][s] + neg(bank[s*5+4]) * ry2[c][s];
      r = (longint'(acc_m) + 64'sd8192) >>> 14;
      y = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
      rx2[c][s] = rx1[c][s];
      rx1[c][s] = v;
      ry2[c][s] = ry1[c][s];
      ry1[c][s] = y;
      v = y;
    end
    return v;
  endfunction

  always @(negedge clk)
    if (out_valid) begin
      if (exp_v.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_v = exp_v.pop_front();
        mon_c = exp_c.pop_front();
        chk("out_chan", int'(out_chan), mon_c);
        chk(out_chan ? "out_right" : "out_left", out_chan ? int'(out_right) : int'(out_left), mon_v);
      end
    end

  task automatic do_reset();
    reset = 1'b1;
    l_r_clk = 1'b0;
    sample_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_v.delete();
    exp_c.delete();
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 3; s++) begin
        rx1[c][s] = 0; rx2[c][s] = 0; ry1[c][s] = 0; ry2[c][s] = 0;
      end
  endtask

  task automatic send(input int x, input bit keep);
    @(posedge clk);
    #1 l_r_clk = ~l_r_clk;
    sample_in = 16'(x);
    if (keep) begin
      exp_c.push_back(int'(l_r_clk));
      exp_v.push_back(ref_run(int'(l_r_clk), x));
    end
  endtask

  task automatic drain(input string tag, input int cycles);
    repeat (cycles) @(posedge clk);
    #1 chk(tag, exp_v.size(), 0);
  endtask

  task automatic sendw(input int x);
    send(x, 1'b1);
    repeat (30) @(posedge clk);
  endtask

  task automatic set_bank(input int s, input int b0, input int b1, input int b2, input int a1, input int a2);
    bank[s*5] = 16'(b0); bank[s*5+1] = 16'(b1); bank[s*5+2] = 16'(b2);
    bank[s*5+3] = 16'(a1); bank[s*5+4] = 16'(a2);
  endtask

  task automatic prime();
    sendw(0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = '0;
    do_reset();
    chk("rst_out_left", int'(out_left), 0);
    chk("rst_out_right", int'(out_right), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_mac_rst", int'(mac_rst), 1);
    chk("rst_mac_ce", int'(mac_ce), 0);
    chk("rst_mac_a", int'(mac_a), 0);
    chk("rst_mac_b", int'(mac_b), 0);
    chk("rst_coef_addr", int'(coef_addr), 0);

    set_bank(0, 16384, 0, 0, 0, 0);
    set_bank(1, 16384, 0, 0, 0, 0);
    set_bank(2, 16384, 0, 0, 0, 0);
    prime();
    send(1000, 1'b1);
    @(posedge clk);
    #1 chk("busy_cycle0", int'(busy), 0);
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1 k++;
      if (out_valid) break;
    end
    chk("latency", k, 23);
    chk("pass_left", int'(out_left), 1000);
    drain("pass_drained", 10);

    do_reset();
    set_bank(0, 8192, 0, 0, -8192, 0);
    prime();
    sendw(16384);
    sendw(0);
    sendw(0);
    sendw(0);
    sendw(0);
    drain("iir_drained", 5);
    chk("iir_left_last", int'(out_left), 2048);
    chk("iir_right_zero", int'(out_right), 0);

    do_reset();
    for (int s = 0; s < 3; s++) set_bank(s, 32767, 0, 0, 0, 0);
    prime();
    sendw(32767);
    sendw(-32768);
    drain("sat_drained", 5);
    chk("sat_pos", int'(out_left), 32767);
    chk("sat_neg", int'(out_right), -32768);

    do_reset();
    set_bank(0, 16384, 0, 0, -32768, 0);
    set_bank(1, 16384, 0, 0, 0, 0);
    set_bank(2, 16384, 0, 0, 0, 0);
    prime();
    sendw(100);
    sendw(0);
    sendw(0);
    sendw(0);
    drain("neg_drained", 5);

    do_reset();
    set_bank(0, 8192, 4096, 0, -4096, 0);
    set_bank(1, 16384, 0, 2048, 0, 1024);
    set_bank(2, 12000, -3000, 1000, 2000, -1500);
    prime();
    sendw(1000);
    sendw(-1000);
    for (int i = 0; i < 6; i++) sendw(0);
    drain("xtalk_drained", 5);

    do_reset();
    for (int i = 0; i < 15; i++) bank[i] = 16'($urandom_range(16383) - 8192);
    prime();
    for (int i = 0; i < 16; i++) sendw(int'($signed(16'($urandom))));
    drain("rand_drained", 5);
    chk("ovr_before", int'(overrun), 0);

    send(int'($signed(16'($urandom))), 1'b1);
    repeat (5) @(posedge clk);
    send(int'($signed(16'($urandom))), 1'b0);
    repeat (3) @(posedge clk);
    send(int'($signed(16'($urandom))), 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("ovr_set", int'(overrun), 1);
    drain("ovr_drained", 70);

    send(500, 1'b1);
    k = 0;
    while (coef_addr != 4'd7 && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reached_stage1", int'(coef_addr), 7);
    do_reset();
    chk("abort_overrun", int'(overrun), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    prime();
    sendw(500);
    sendw(-700);
    drain("abort_drained", 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
